// File: rtl/ysyx_25060170_wbu_pkg.sv
// Shared definitions for the write-back unit: load funct3 codes, state encoding, width defaults.
// Used by ysyx_25060170_wbu and ysyx_25060170_load_ext.
package ysyx_25060170_wbu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_WRITE     = 2'd2
  } wbu_state_e;

endpackage

// File: rtl/ysyx_25060170_load_ext.sv
// Combinational load data extractor: picks the byte/half/word lane from a word-aligned read
// and sign/zero-extends it; flags misaligned accesses and undefined funct3 codes.
module ysyx_25060170_load_ext
  import ysyx_25060170_wbu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      lane_i,
  output logic [XLEN-1:0] data_o,
  output logic            err_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata_i[{lane_i, 3'b000} +: 8];
  assign half_v = rdata_i[{lane_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    unique case (funct3_i)
      F3_LB:  data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH: begin
        data_o = {{(XLEN-16){half_v[15]}}, half_v};
        err_o  = lane_i[0];
      end
      F3_LHU: begin
        data_o = {{(XLEN-16){1'b0}}, half_v};
        err_o  = lane_i[0];
      end
      F3_LW: begin
        data_o = rdata_i;
        err_o  = (lane_i != 2'b00);
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_25060170_wbu.sv
// Write-back unit: accepts one completed instruction, waits for load data if needed, then
// issues one registered GPR write and a commit pulse. Optional trace ports: YSYX_25060170_WBU_TRACE_EN.
module ysyx_25060170_wbu
  import ysyx_25060170_wbu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_wen,
  input  logic [XLEN-1:0] in_result,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_pc,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            gpr_we,
  output logic [RA_W-1:0] gpr_writer,
  output logic [XLEN-1:0] gpr_wd,
  output logic            commit_valid,
`ifdef YSYX_25060170_WBU_TRACE_EN
  output logic [XLEN-1:0] commit_pc,
  output logic [XLEN-1:0] commit_rd_val,
`endif
  output logic            commit_err
);

  wbu_state_e state_q, state_d;

  // Instruction fields captured at the handshake, consumed when the load returns.
  logic [RA_W-1:0] rd_q;
  logic            wen_q;
  logic [2:0]      funct3_q;
  logic [1:0]      lane_q;
  logic [XLEN-1:0] pc_q;

  logic            gpr_we_q, commit_valid_q, commit_err_q;
  logic [RA_W-1:0] gpr_writer_q;
  logic [XLEN-1:0] gpr_wd_q;

  logic [XLEN-1:0] ext_data;
  logic            ext_err;

  logic            wb_fire;
  logic [RA_W-1:0] wb_rd;
  logic            wb_wen;
  logic [XLEN-1:0] wb_data;
  logic            wb_err;
  logic [XLEN-1:0] wb_pc;
  logic            wb_we;
  logic            handshake;

  ysyx_25060170_load_ext #(.XLEN(XLEN)) u_load_ext (
    .rdata_i  (mem_rdata),
    .funct3_i (funct3_q),
    .lane_i   (lane_q),
    .data_o   (ext_data),
    .err_o    (ext_err)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign handshake = in_valid && in_ready;

  // wb_* describes the write that will be presented in the following WRITE cycle.
  always_comb begin
    state_d = state_q;
    wb_fire = 1'b0;
    wb_rd   = rd_q;
    wb_wen  = wen_q;
    wb_data = ext_data;
    wb_err  = ext_err;
    wb_pc   = pc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          if (in_is_load) begin
            state_d = ST_LOAD_WAIT;
          end else begin
            state_d = ST_WRITE;
            wb_fire = 1'b1;
            wb_rd   = in_rd;
            wb_wen  = in_wen;
            wb_data = in_result;
            wb_err  = 1'b0;
            wb_pc   = in_pc;
          end
        end
      end
      ST_LOAD_WAIT: begin
        if (mem_rvalid) begin
          state_d = ST_WRITE;
          wb_fire = 1'b1;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign wb_we = wb_fire && wb_wen && (wb_rd != '0) && !wb_err;

  always_ff @(posedge clk) begin
    if (handshake) begin
      rd_q     <= in_rd;
      wen_q    <= in_wen;
      funct3_q <= in_funct3;
      lane_q   <= in_result[1:0];
      pc_q     <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      gpr_we_q       <= 1'b0;
      gpr_writer_q   <= '0;
      gpr_wd_q       <= '0;
      commit_valid_q <= 1'b0;
      commit_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      gpr_we_q       <= wb_we;
      commit_valid_q <= wb_fire;
      commit_err_q   <= wb_fire && wb_err;
      if (wb_fire) begin
        gpr_writer_q <= wb_rd;
        gpr_wd_q     <= wb_data;
      end
    end
  end

  assign gpr_we       = gpr_we_q;
  assign gpr_writer   = gpr_writer_q;
  assign gpr_wd       = gpr_wd_q;
  assign commit_valid = commit_valid_q;
  assign commit_err   = commit_err_q;

`ifdef YSYX_25060170_WBU_TRACE_EN
  logic [XLEN-1:0] commit_pc_q, commit_rd_val_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_pc_q     <= '0;
      commit_rd_val_q <= '0;
    end else if (wb_fire) begin
      commit_pc_q     <= wb_pc;
      commit_rd_val_q <= wb_we ? wb_data : '0;
    end
  end

  assign commit_pc     = commit_pc_q;
  assign commit_rd_val = commit_rd_val_q;
`else
  logic unused_trace;
  assign unused_trace = ^{wb_pc};
`endif

endmodule

// File: doc/ysyx_25060170_wbu.md
Name: ysyx_25060170_wbu

Overview:
Write-back unit; the producer side of the GPR write port (we / write-register / write-data).
- Accepts a completed instruction from the EXU/LSU over a valid/ready handshake.
- For loads, waits for the memory read response, then aligns and extends the returned data.
- Issues exactly one registered GPR write per instruction and a one-cycle commit pulse toward IFU/difftest.

Parameters:
- XLEN, 32, data width of results and GPR write data
- RA_W, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  WBU can accept an instruction
- in_rd  in  RA_W  destination register
- in_wen  in  1  instruction writes rd
- in_result  in  XLEN  ALU result, or load address for loads
- in_is_load  in  1  result comes from memory
- in_funct3  in  3  load size/sign code
- in_pc  in  XLEN  instruction PC
- mem_rvalid  in  1  memory read data valid
- mem_rdata  in  XLEN  memory read word (word-aligned)
- gpr_we  out  1  GPR write enable
- gpr_writer  out  RA_W  GPR destination index
- gpr_wd  out  XLEN  GPR write data
- commit_valid  out  1  instruction retired (1-cycle pulse)
- commit_err  out  1  retired with misaligned/illegal load (1-cycle pulse, with commit_valid)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state=IDLE; gpr_we=0, gpr_writer=0, gpr_wd=0, commit_valid=0, commit_err=0; in_ready=1 in the cycle after reset.
- States: IDLE, LOAD_WAIT, WRITE.
- IDLE:
  - in_ready=1 (combinational from state only; never from in_valid).
  - Handshake fires when in_valid && in_ready.
  - On handshake, latch rd, wen, result, is_load, funct3, result[1:0], pc.
  - Next state: LOAD_WAIT if is_load, else WRITE.
- LOAD_WAIT:
  - in_ready=0.
  - On mem_rvalid: latch extracted load data; next state WRITE.
  - Otherwise hold indefinitely.
- WRITE:
  - in_ready=0.
  - Registered outputs are valid for exactly this one cycle:
    - gpr_we = wen && rd!=0 && !err
    - gpr_writer = rd
    - gpr_wd = data
    - commit_valid = 1
    - commit_err = err
  - Next state: IDLE.
- Latency:
  - Non-load accepted at cycle N: write/commit at N+1.
  - Load with mem_rvalid at cycle M: write/commit at M+1.
  - Throughput: one instruction per 2 cycles (IDLE, WRITE) for non-loads.
- Outside WRITE: gpr_we=0 and commit_valid=0. gpr_writer and gpr_wd hold their last values.
- Load extract, lane = addr[1:0]:
  - 000 LB: sign-extend byte[lane]
  - 100 LBU: zero-extend byte[lane]
  - 001 LH: sign-extend half[lane[1]]
  - 101 LHU: zero-extend half[lane[1]]
  - 010 LW: full word
- Error (err=1, no GPR write, commit still pulses):
  - LH/LHU with lane[0]=1
  - LW with lane!=0
  - funct3 of 011, 110 or 111
- rd==0 or wen==0: no write; commit_valid still pulses.
- mem_rvalid outside LOAD_WAIT: ignored, no state change.
- in_valid while in_ready=0: ignored; upstream must hold.
- rst asserted in any state (including LOAD_WAIT with a pending response): return to IDLE. A response arriving after reset is ignored. No write is issued for the aborted instruction.

Optional Feature:
- Macro: YSYX_25060170_WBU_TRACE_EN.
- Defined:
  - Adds output commit_pc [XLEN] and output commit_rd_val [XLEN].
  - commit_pc = latched pc; commit_rd_val = data written (0 when no write).
  - Both valid with commit_valid; reset to 0.
- Undefined: these ports and their registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package/header:
  - load funct3 constants LB/LH/LW/LBU/LHU
  - WBU state encoding (2 bits)
  - XLEN/RA_W defaults
- Sub-module ysyx_25060170_load_ext:
  - Purely combinational (rdata, funct3, lane) -> (data, err).
  - Reused by difftest/LSU checks.

Test Plan:
- Reset then in_valid, rd=5, wen=1, is_load=0, result=0xDEADBEEF -> next cycle: gpr_we=1, gpr_writer=5, gpr_wd=0xDEADBEEF, commit_valid=1; in_ready=0 for that cycle.
- Load LB, addr=0x..03, mem_rdata=0x80112233 after 3 wait cycles -> in_ready=0 throughout; write rd with 0xFFFFFF80 one cycle after mem_rvalid.
- LHU addr lane 2, rdata=0xABCD1234 -> 0x0000ABCD; LH lane 1 -> commit_err=1, gpr_we=0, commit_valid=1.
- rd=0, wen=1, result=0x1234 -> gpr_we=0, commit_valid=1; stray mem_rvalid in IDLE -> no effect.
- Back-to-back non-load instructions with in_valid held high -> accepts every 2nd cycle, writes in order, no instruction lost.
- rst asserted in LOAD_WAIT, mem_rvalid arriving the next cycle -> no write, state IDLE, in_ready=1; with TRACE_EN defined, commit_pc/commit_rd_val read 0 after reset.
